// File: rtl/ser_tx_pkg.sv
// Shared types and defaults for the LSB-first serialiser: FSM state encoding and default word width.
package ser_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int SER_TX_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/ser_tx.sv
// Parallel-to-serial, LSB first; bit 0 on q the cycle after accept, back-to-back frames, all outputs but in_ready registered.
// in_ready only in IDLE or the final-bit cycle; SER_TX_PARITY_EN appends an even-parity bit (frame WIDTH+1 cycles).
module ser_tx
  import ser_tx_pkg::*;
#(
  parameter int WIDTH = SER_TX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_first,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef SER_TX_PARITY_EN
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             q_first_q, q_first_d;
  logic             done_q, done_d;
  logic             accept;

  // done_q marks the final-bit cycle, which is exactly when a new word may enter
  assign in_ready = (state_q == IDLE) || done_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    q_d       = 1'b0;
    q_valid_d = 1'b0;
    q_first_d = 1'b0;
    done_d    = 1'b0;
    if (accept) begin
      state_d   = SHIFT;
      sh_d      = in_data;
      cnt_d     = '0;
      q_d       = in_data[0];
      q_valid_d = 1'b1;
      q_first_d = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q != LAST) begin
            // rotate rather than shift so the full word survives for the parity bit
            sh_d      = {sh_q[0], sh_q[WIDTH-1:1]};
            cnt_d     = cnt_q + CW'(1);
            q_d       = sh_q[1];
            q_valid_d = 1'b1;
`ifndef SER_TX_PARITY_EN
            done_d    = (cnt_q == PENULT);
`endif
          end else begin
`ifdef SER_TX_PARITY_EN
            state_d   = PAR;
            q_d       = ^sh_q;
            q_valid_d = 1'b1;
            done_d    = 1'b1;
`else
            state_d   = IDLE;
`endif
          end
        end
`ifdef SER_TX_PARITY_EN
        PAR:     state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      q_q       <= 1'b0;
      q_valid_q <= 1'b0;
      q_first_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_first_q <= q_first_d;
      done_q    <= done_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign q_first = q_first_q;
  assign done    = done_q;

endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits, legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_data  input  WIDTH  parallel word to serialise; sampled only on accept.
REQ-005 Port: in_valid  input  1  in_data holds a word for transmission.
REQ-006 Port: in_ready  output  1  block can accept a word this cycle.
REQ-007 Port: q  output  1  serial data bit, LSB first.
REQ-008 Port: q_valid  output  1  q carries a frame bit this cycle.
REQ-009 Port: q_first  output  1  q carries bit 0 of a frame.
REQ-010 Port: done  output  1  one-cycle pulse marking the final bit of a frame.

Function
REQ-011 States SHALL be IDLE and SHIFT, plus PAR when the parity feature is compiled in.
REQ-012 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-013 in_ready SHALL be 1 in IDLE, and 1 in the cycle presenting the final frame bit; 0 otherwise.
REQ-014 On accept, the word SHALL load into a WIDTH-bit shift register, the bit counter SHALL clear, and the state SHALL go to SHIFT.
REQ-015 Latency: bit 0 SHALL appear on q in the cycle immediately following the accepting edge.
REQ-016 All outputs except in_ready SHALL be driven directly from flops, with no combinational path from any input.
REQ-017 In SHIFT, q SHALL present one bit per cycle, LSB first, for exactly WIDTH cycles, with q_valid=1.
REQ-018 q_first SHALL be 1 only in the cycle presenting bit 0.
REQ-019 The bit counter SHALL be $clog2(WIDTH) bits wide, count 0..WIDTH-1, and never wrap within a frame.
REQ-020 done SHALL be 1 only in the cycle presenting the final frame bit: bit WIDTH-1, or the parity bit when that feature is enabled.
REQ-021 Final-bit cycle with accept: the next frame's bit 0 SHALL follow with no gap (back-to-back), and q_first=1.
REQ-022 Final-bit cycle without accept: the next state SHALL be IDLE.
REQ-023 In IDLE, q SHALL be 0, q_valid 0, q_first 0, and done 0.
REQ-024 in_valid while in_ready=0 SHALL be ignored, with no effect on the frame in progress.
REQ-025 Changes of in_data after accept SHALL NOT affect the frame in progress.

Reset
REQ-026 rst_n=0 SHALL immediately force the state to IDLE, without waiting for a clock edge.
REQ-027 During reset, q, q_valid, q_first, and done SHALL be 0, the shift register and counter SHALL be 0, and in_ready SHALL be 1.
REQ-028 Reset mid-frame SHALL abort the frame; no partial-frame bits or done SHALL follow reset release.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro SER_TX_PARITY_EN SHALL control an even-parity bit appended to each frame.
REQ-031 With SER_TX_PARITY_EN defined, after bit WIDTH-1 the state SHALL go to PAR for one cycle.
REQ-032 In PAR, q SHALL be the XOR of all WIDTH bits, with q_valid=1 and done=1; the frame is WIDTH+1 cycles.
REQ-033 Without SER_TX_PARITY_EN, PAR and the parity logic SHALL be absent, and the frame is WIDTH cycles.

Structure
REQ-034 Package ser_tx_pkg SHALL hold the state enum (IDLE, SHIFT, PAR) and the default WIDTH constant.
REQ-035 The design SHALL be a single module with no sub-module; the counter and shifter are inline.

Verification
REQ-036 WIDTH=8, accept 8'hA5: q over 8 cycles = 1,0,1,0,0,1,0,1; q_first on cycle 1; done on cycle 8; then IDLE.
REQ-037 Back-to-back: in_valid held high with 8'h01 then 8'h80 -> 16 contiguous q_valid cycles; q=1 on cycles 1 and 16 only; done on cycles 8 and 16.
REQ-038 Busy rejection: in_valid=1 with 8'hFF on cycles 2-6 of an 8'h00 frame -> q stays 0 for all 8 bits; in_ready=0 on cycles 2-7.
REQ-039 Reset mid-frame: rst_n low at bit 3 of 8'hFF -> q and q_valid drop to 0 without a clock edge; no done; in_ready=1 after release.
REQ-040 With SER_TX_PARITY_EN, 8'h07: 9 q_valid cycles, parity bit q=1, done on cycle 9; with 8'h03, parity bit q=0.
